pc_fetch_sequencer: RTL and testbench

//  Next-address controller for the 32-bit ProgramCounter register. Drives its Address

---
 rtl/pc_fetch_sequencer_if.sv | 31 +++
 rtl/pc_fetch_sequencer.sv | 100 ++++++++++
 tb/tb_pc_fetch_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch sequencer bus: PC feedback, hazard/branch/debug
// controls in; next address, ack and status out.
interface pc_fetch_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] PCIn;
  logic              Stall;
  logic              RedirectReq;
  logic [ADDR_W-1:0] RedirectAddr;
  logic              Halt;
  logic              Resume;
  logic [ADDR_W-1:0] NextAddress;
  logic              RedirectAck;
  logic              FetchValid;
  logic              Flush;
  logic [1:0]        State;

  modport master (
    output PCIn, Stall, RedirectReq, RedirectAddr,
    output Halt, Resume,
    input  NextAddress, RedirectAck, FetchValid,
    input  Flush, State
  );

  modport slave (
    input  PCIn, Stall, RedirectReq, RedirectAddr,
    input  Halt, Resume,
    output NextAddress, RedirectAck, FetchValid,
    output Flush, State
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Next-address controller for the ProgramCounter.
// Ports: Clk, Reset (sync, high), bus (slave side).
module pc_fetch_sequencer #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       INC          = 4,
  parameter int unsigned       FLUSH_CYCLES = 2
) (
  input logic                  Clk,
  input logic                  Reset,
  pc_fetch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0] redir_addr;
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] next_addr;
  logic              ack;

  assign redir_addr = {bus.RedirectAddr[ADDR_W-1:2], 2'b00};
  // Truncating add: top of memory wraps to zero.
  assign seq_addr = bus.Stall ? bus.PCIn
                              : bus.PCIn + ADDR_W'(INC);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    next_addr = bus.PCIn;
    ack       = 1'b0;
    case (state_q)
      FLUSH: begin
        // Halt waits here; it is seen again in RUN.
        if (bus.RedirectReq) begin
          ack       = 1'b1;
          next_addr = redir_addr;
          cnt_d     = 4'(FLUSH_CYCLES);
        end else begin
          next_addr = seq_addr;
          if (cnt_q <= 4'd1) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      HALT: begin
        if (bus.RedirectReq) begin
          ack       = 1'b1;
          next_addr = redir_addr;
        end else if (bus.Resume && !bus.Halt) begin
          state_d = RUN;
        end
      end
      default: begin
        if (bus.RedirectReq) begin
          ack       = 1'b1;
          next_addr = redir_addr;
          state_d   = FLUSH;
          cnt_d     = 4'(FLUSH_CYCLES);
        end else if (bus.Halt) begin
          state_d = HALT;
        end else begin
          next_addr = seq_addr;
        end
      end
    endcase
    if (Reset) begin
      next_addr = RESET_VECTOR;
      ack       = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.NextAddress = next_addr;
  assign bus.RedirectAck = ack;
  assign bus.FetchValid  = (state_q != HALT) & ~bus.Stall & ~Reset;
  assign bus.Flush       = (state_q == FLUSH) & ~Reset;
  // Encoding 3 never occurs but reads as RUN.
  assign bus.State       = (Reset || state_q == 2'd3)
                         ? 2'd0 : state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a
// ProgramCounter model closing the PC loop.
module tb_pc_fetch_sequencer;
  logic Clk;
  logic Reset;
  int   errors;
  int   checks;

  pc_fetch_sequencer_if #(.ADDR_W(32)) bus ();

  pc_fetch_sequencer #(
    .ADDR_W(32),
    .RESET_VECTOR(32'h0),
    .INC(4),
    .FLUSH_CYCLES(2)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) bus.PCIn <= bus.NextAddress;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic st(input string tag,
                    input logic [31:0] pc,
                    input logic [31:0] na,
                    input logic fv,
                    input logic fl,
                    input logic [1:0] s);
    chk({tag, ".pc"}, bus.PCIn, pc);
    chk({tag, ".na"}, bus.NextAddress, na);
    chk({tag, ".fv"}, 32'(bus.FetchValid), 32'(fv));
    chk({tag, ".fl"}, 32'(bus.Flush), 32'(fl));
    chk({tag, ".st"}, 32'(bus.State), 32'(s));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    Reset  = 1'b1;
    bus.Stall        = 1'b0;
    bus.RedirectReq  = 1'b0;
    bus.RedirectAddr = '0;
    bus.Halt         = 1'b0;
    bus.Resume       = 1'b0;
    #1;
    chk("rst.na", bus.NextAddress, 32'h0);
    chk("rst.fv", 32'(bus.FetchValid), 32'h0);
    chk("rst.fl", 32'(bus.Flush), 32'h0);
    chk("rst.st", 32'(bus.State), 32'h0);
    tick();
    tick();
    chk("rst2.fv", 32'(bus.FetchValid), 32'h0);
    Reset = 1'b0;
    #1;
    st("seq0", 32'h0, 32'h4, 1'b1, 1'b0, 2'd0);
    tick();
    st("seq1", 32'h4, 32'h8, 1'b1, 1'b0, 2'd0);
    tick();
    st("seq2", 32'h8, 32'hC, 1'b1, 1'b0, 2'd0);
    tick();
    st("seq3", 32'hC, 32'h10, 1'b1, 1'b0, 2'd0);
    tick();
    bus.Stall = 1'b1;
    #1;
    st("stl0", 32'h10, 32'h10, 1'b0, 1'b0, 2'd0);
    tick();
    st("stl1", 32'h10, 32'h10, 1'b0, 1'b0, 2'd0);
    tick();
    st("stl2", 32'h10, 32'h10, 1'b0, 1'b0, 2'd0);
    tick();
    bus.Stall = 1'b0;
    #1;
    st("stl3", 32'h10, 32'h14, 1'b1, 1'b0, 2'd0);
    tick();
    chk("stl4.pc", bus.PCIn, 32'h14);

    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    tick();
    bus.RedirectReq  = 1'b1;
    bus.RedirectAddr = 32'h103;
    #1;
    chk("rd.ack", 32'(bus.RedirectAck), 32'h1);
    st("rd0", 32'h8, 32'h100, 1'b1, 1'b0, 2'd0);
    tick();
    bus.RedirectReq = 1'b0;
    #1;
    chk("rd1.ack", 32'(bus.RedirectAck), 32'h0);
    st("rd1", 32'h100, 32'h104, 1'b1, 1'b1, 2'd1);
    tick();
    st("rd2", 32'h104, 32'h108, 1'b1, 1'b1, 2'd1);
    tick();
    st("rd3", 32'h108, 32'h10C, 1'b1, 1'b0, 2'd0);

    bus.RedirectReq  = 1'b1;
    bus.RedirectAddr = 32'h50;
    tick();
    bus.RedirectReq = 1'b0;
    #1;
    st("rr1", 32'h50, 32'h54, 1'b1, 1'b1, 2'd1);
    tick();
    bus.RedirectReq  = 1'b1;
    bus.RedirectAddr = 32'h200;
    #1;
    chk("rr2.ack", 32'(bus.RedirectAck), 32'h1);
    st("rr2", 32'h54, 32'h200, 1'b1, 1'b1, 2'd1);
    tick();
    bus.RedirectReq = 1'b0;
    #1;
    st("rr3", 32'h200, 32'h204, 1'b1, 1'b1, 2'd1);
    tick();
    st("rr4", 32'h204, 32'h208, 1'b1, 1'b1, 2'd1);
    tick();
    st("rr5", 32'h208, 32'h20C, 1'b1, 1'b0, 2'd0);

    bus.RedirectReq  = 1'b1;
    bus.RedirectAddr = 32'h18;
    tick();
    bus.RedirectReq = 1'b0;
    tick();
    tick();
    bus.Halt = 1'b1;
    #1;
    st("h0", 32'h20, 32'h20, 1'b1, 1'b0, 2'd0);
    tick();
    st("h1", 32'h20, 32'h20, 1'b0, 1'b0, 2'd2);
    tick();
    st("h2", 32'h20, 32'h20, 1'b0, 1'b0, 2'd2);
    bus.RedirectReq  = 1'b1;
    bus.RedirectAddr = 32'h40;
    #1;
    chk("h3.ack", 32'(bus.RedirectAck), 32'h1);
    chk("h3.na", bus.NextAddress, 32'h40);
    tick();
    bus.RedirectReq = 1'b0;
    bus.Resume      = 1'b1;
    #1;
    st("h4", 32'h40, 32'h40, 1'b0, 1'b0, 2'd2);
    tick();
    bus.Resume = 1'b0;
    #1;
    chk("h5.st", 32'(bus.State), 32'd2);
    bus.Halt   = 1'b0;
    bus.Resume = 1'b1;
    #1;
    chk("h6.na", bus.NextAddress, 32'h40);
    tick();
    bus.Resume = 1'b0;
    #1;
    st("h7", 32'h40, 32'h44, 1'b1, 1'b0, 2'd0);
    tick();
    chk("h8.pc", bus.PCIn, 32'h44);

    bus.RedirectReq  = 1'b1;
    bus.RedirectAddr = 32'hFFFF_FFFF;
    #1;
    chk("w0.na", bus.NextAddress, 32'hFFFF_FFFC);
    tick();
    bus.RedirectReq = 1'b0;
    #1;
    st("w1", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1, 2'd1);
    tick();
    Reset            = 1'b1;
    bus.RedirectReq  = 1'b1;
    bus.RedirectAddr = 32'h300;
    #1;
    chk("rf.ack", 32'(bus.RedirectAck), 32'h0);
    st("rf0", 32'h0, 32'h0, 1'b0, 1'b0, 2'd0);
    tick();
    Reset           = 1'b0;
    bus.RedirectReq = 1'b0;
    #1;
    st("rf1", 32'h0, 32'h4, 1'b1, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
